// File: rtl/host_reg_responder_pkg.sv
// Shared types and constants for the host register responder.
package host_pkg;

  // Direction of a host access as carried on host_req_wr.
  typedef enum logic {
    HOST_ACCESS_KIND_RD = 1'b0,
    HOST_ACCESS_KIND_WR = 1'b1
  } host_access_kind_t;

  // Word indices of the fixed registers; scratch space starts at SCRATCH0.
  localparam int HOST_REG_ID         = 0;
  localparam int HOST_REG_ACCESS_CNT = 1;
  localparam int HOST_REG_SCRATCH0   = 2;

  // Responder FSM: take a request, burn wait states, present the response.
  typedef enum logic [1:0] {
    HOST_RSP_IDLE,
    HOST_RSP_WAIT,
    HOST_RSP_RESP
  } host_rsp_state_t;

endpackage

// File: rtl/host_reg_responder_reg_bank.sv
// Register bank behind the host responder: ID, access counter, scratch words.
// A commit strobe performs the access (write or read sample) and latches the
// response data and error flag, which then hold until the next commit.
module host_reg_bank
  import host_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 32,
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hC0DE_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              cnt_inc,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  logic [DATA_W-1:0] scratch [HOST_REG_SCRATCH0:NUM_REGS-1];
  logic [DATA_W-1:0] access_cnt;

  logic [31:0]       addr_ext;
  logic              in_range;
  logic              acc_err;
  logic [DATA_W-1:0] rd_value;

  // Decode the access: range check on the zero-extended address, RO check, read mux.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    rd_value = '0;
    addr_ext = 32'(addr);
    in_range = addr_ext < 32'(NUM_REGS);
    acc_err  = !in_range || (wr && (addr_ext < 32'(HOST_REG_SCRATCH0)));
    if (addr_ext == 32'(HOST_REG_ID)) begin
      rd_value = DATA_W'(ID_VALUE);
    end else if (addr_ext == 32'(HOST_REG_ACCESS_CNT)) begin
      rd_value = access_cnt;
    end else begin
      for (int i = HOST_REG_SCRATCH0; i < NUM_REGS; i++) begin
        if (addr_ext == 32'(i)) rd_value = scratch[i];
      end
    end
  end

  // Commit the access, latch the response, and count completed handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata      <= '0;
      err        <= 1'b0;
      access_cnt <= '0;
      // NOTE: the scratch words are architecturally visible after reset, so they are
      // cleared here; this small bank is flops, not a RAM macro.
      for (int i = HOST_REG_SCRATCH0; i < NUM_REGS; i++) scratch[i] <= '0;
    end else begin
      // NOTE: non-blocking updates, so a read of ACCESS_CNT sees the pre-increment value.
      if (cnt_inc) access_cnt <= access_cnt + 1'b1;
      if (commit) begin
        err   <= acc_err;
        rdata <= (wr || acc_err) ? '0 : rd_value;
        for (int i = HOST_REG_SCRATCH0; i < NUM_REGS; i++) begin
          if (wr && !acc_err && addr_ext == 32'(i)) scratch[i] <= wdata;
        end
      end
    end
  end

endmodule

// File: rtl/host_reg_responder.sv
// Host access responder: accepts one request, inserts WAIT_CYCLES wait states,
// commits it into the register bank and returns the response via valid/ready.
module host_reg_responder
  import host_pkg::*;
#(
  parameter int          ADDR_W      = 8,
  parameter int          DATA_W      = 32,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hC0DE_0001
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_req_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rsp_valid,
  input  logic              host_rsp_ready,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rsp_err
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  host_rsp_state_t   state, next_state;
  logic [3:0]        wait_cnt;
  host_access_kind_t cap_kind;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;

  logic              accept;
  logic              commit;
  logic              cnt_inc;
  logic              bank_wr;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wdata;

  assign accept = host_req_valid && host_req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= HOST_RSP_IDLE;
    else     state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      HOST_RSP_IDLE: if (accept) next_state = (WAIT_CYCLES > 0) ? HOST_RSP_WAIT : HOST_RSP_RESP;
      HOST_RSP_WAIT: if (wait_cnt == 4'd0) next_state = HOST_RSP_RESP;
      HOST_RSP_RESP: if (host_rsp_ready) next_state = HOST_RSP_IDLE;
      default:       next_state = HOST_RSP_IDLE;
    endcase
  end

  // Outputs and bank controls; with zero wait states the commit uses the live request.
  always_comb begin
    host_req_ready = (state == HOST_RSP_IDLE);
    host_rsp_valid = (state == HOST_RSP_RESP);
    commit         = (state != HOST_RSP_RESP) && (next_state == HOST_RSP_RESP);
    cnt_inc        = (state == HOST_RSP_RESP) && host_rsp_ready;
    if (state == HOST_RSP_IDLE) begin
      bank_wr    = host_req_wr;
      bank_addr  = host_addr;
      bank_wdata = host_wdata;
    end else begin
      bank_wr    = (cap_kind == HOST_ACCESS_KIND_WR);
      bank_addr  = cap_addr;
      bank_wdata = cap_wdata;
    end
  end

  // Request capture on accept and wait-state countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt  <= 4'd0;
      cap_kind  <= HOST_ACCESS_KIND_RD;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (accept) begin
      wait_cnt  <= WAIT_LOAD;
      cap_kind  <= host_access_kind_t'(host_req_wr);
      cap_addr  <= host_addr;
      cap_wdata <= host_wdata;
    end else if (state == HOST_RSP_WAIT && wait_cnt != 4'd0) begin
      wait_cnt  <= wait_cnt - 4'd1;
    end
  end

  host_reg_bank #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .ID_VALUE (ID_VALUE)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .commit  (commit),
    .wr      (bank_wr),
    .addr    (bank_addr),
    .wdata   (bank_wdata),
    .cnt_inc (cnt_inc),
    .rdata   (host_rdata),
    .err     (host_rsp_err)
  );

endmodule

// File: tb/tb_host_reg_responder.sv
// Self-checking bench for host_reg_responder: a WAIT_CYCLES=2 instance for the
// main scenarios and a WAIT_CYCLES=0 instance for back-to-back traffic.
module tb_host_reg_responder;

  localparam logic [31:0] ID = 32'hC0DE_0001;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b1;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rdata;

  logic        req_valid_z = 1'b0, req_wr_z = 1'b0, rsp_ready_z = 1'b1;
  logic [7:0]  addr_z = '0;
  logic [31:0] wdata_z = '0;
  logic        req_ready_z, rsp_valid_z, rsp_err_z;
  logic [31:0] rdata_z;

  int vectors = 0;
  int miscompares = 0;

  exp_t        exp_a[$];
  exp_t        exp_z[$];
  logic [31:0] m_scratch [2][8];
  logic [31:0] m_cnt [2];

  always #5 clk = ~clk;

  host_reg_responder #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .host_req_valid(req_valid), .host_req_ready(req_ready), .host_req_wr(req_wr),
    .host_addr(addr), .host_wdata(wdata),
    .host_rsp_valid(rsp_valid), .host_rsp_ready(rsp_ready),
    .host_rdata(rdata), .host_rsp_err(rsp_err)
  );

  host_reg_responder #(.WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst),
    .host_req_valid(req_valid_z), .host_req_ready(req_ready_z), .host_req_wr(req_wr_z),
    .host_addr(addr_z), .host_wdata(wdata_z),
    .host_rsp_valid(rsp_valid_z), .host_rsp_ready(rsp_ready_z),
    .host_rdata(rdata_z), .host_rsp_err(rsp_err_z)
  );

  // Reference model of the register map; di selects the model copy (0: dut, 1: dut_z).
  task automatic model_apply(input int di, input logic w, input logic [7:0] a,
                             input logic [31:0] d, output exp_t e);
    e.rdata = '0;
    e.err   = 1'b0;
    if (a >= 8'd8 || (w && a < 8'd2)) begin
      e.err = 1'b1;
    end else if (w) begin
      m_scratch[di][a[2:0]] = d;
    end else if (a == 8'd0) begin
      e.rdata = ID;
    end else if (a == 8'd1) begin
      e.rdata = m_cnt[di];
    end else begin
      e.rdata = m_scratch[di][a[2:0]];
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b0; req_valid_z = 1'b0; rsp_ready = 1'b1; rsp_ready_z = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = '0;
      for (int r = 0; r < 8; r++) m_scratch[d][r] = '0;
    end
    exp_a.delete();
    exp_z.delete();
  endtask

  // One complete access on dut with rsp_ready high: accept, latency, response data.
  task automatic do_access(input logic w, input logic [7:0] a, input logic [31:0] d, input string tag);
    int   k;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1; req_wr = w; addr = a; wdata = d; rsp_ready = 1'b1;
    k = 0;
    while (req_ready !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s accept: req_ready=%b want 1 (timeout)", tag, req_ready);
      req_valid = 1'b0;
      return;
    end
    model_apply(0, w, a, d, e);
    exp_a.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    k = 1;
    while (rsp_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    vectors++;
    if (k != 3 || rsp_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL %s latency: rsp_valid after %0d cycles want 3", tag, k);
      if (rsp_valid !== 1'b1) return;
    end
    e = exp_a.pop_front();
    vectors++;
    if (rdata !== e.rdata) begin
      miscompares++;
      $display("FAIL %s rdata: got %h want %h", tag, rdata, e.rdata);
    end
    vectors++;
    if (rsp_err !== e.err) begin
      miscompares++;
      $display("FAIL %s err: got %b want %b", tag, rsp_err, e.err);
    end
    m_cnt[0] = m_cnt[0] + 1;
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if ({req_ready, rsp_valid, rdata, rsp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset dut: ready/valid/rdata/err=%b/%b/%h/%b want 1/0/0/0",
               req_ready, rsp_valid, rdata, rsp_err);
    end
    vectors++;
    if ({req_ready_z, rsp_valid_z, rdata_z, rsp_err_z} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset dut_z: ready/valid/rdata/err=%b/%b/%h/%b want 1/0/0/0",
               req_ready_z, rsp_valid_z, rdata_z, rsp_err_z);
    end
  endtask

  task automatic test_id_read();
    do_access(1'b0, 8'd0, 32'h0, "rd_id");
  endtask

  task automatic test_scratch_rw();
    do_access(1'b1, 8'd2, 32'hA5A5_5A5A, "wr_s2");
    do_access(1'b0, 8'd2, 32'h0, "rd_s2");
    do_access(1'b1, 8'd7, 32'h0BAD_F00D, "wr_s7");
    do_access(1'b0, 8'd7, 32'h0, "rd_s7");
  endtask

  task automatic test_errors();
    apply_reset();
    do_access(1'b1, 8'd1, 32'd5, "wr_cnt_ro");
    do_access(1'b0, 8'd8, 32'h0, "rd_oor");
    do_access(1'b0, 8'd1, 32'h0, "rd_cnt");
    do_access(1'b1, 8'd0, 32'hFFFF_FFFF, "wr_id_ro");
    do_access(1'b1, 8'd255, 32'h1234, "wr_oor");
    do_access(1'b0, 8'd0, 32'h0, "rd_id_after");
  endtask

  task automatic test_backpressure();
    int          k;
    exp_t        e;
    logic [31:0] held_rdata;
    logic        held_err;
    do_access(1'b1, 8'd4, 32'h1234_5678, "bp_wr4");
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; addr = 8'd4; rsp_ready = 1'b0;
    model_apply(0, 1'b0, 8'd4, 32'h0, e);
    exp_a.push_back(e);
    @(negedge clk);
    req_wr = 1'b1; addr = 8'd5; wdata = 32'h0000_0055;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    e = exp_a.pop_front();
    held_rdata = e.rdata;
    held_err   = e.err;
    for (int c = 0; c < 10; c++) begin
      vectors++;
      if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rdata !== held_rdata || rsp_err !== held_err) begin
        miscompares++;
        $display("FAIL bp_hold c%0d: ready/valid/rdata/err=%b/%b/%h/%b want 0/1/%h/%b",
                 c, req_ready, rsp_valid, rdata, rsp_err, held_rdata, held_err);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    m_cnt[0] = m_cnt[0] + 1;
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_release: ready/valid=%b/%b want 1/0", req_ready, rsp_valid);
    end
    model_apply(0, 1'b1, 8'd5, 32'h0000_0055, e);
    exp_a.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    e = exp_a.pop_front();
    vectors++;
    if (rsp_valid !== 1'b1 || rdata !== e.rdata || rsp_err !== e.err) begin
      miscompares++;
      $display("FAIL bp_second: valid/rdata/err=%b/%h/%b want 1/%h/%b",
               rsp_valid, rdata, rsp_err, e.rdata, e.err);
    end
    m_cnt[0] = m_cnt[0] + 1;
    do_access(1'b0, 8'd5, 32'h0, "bp_rd5");
    do_access(1'b0, 8'd1, 32'h0, "bp_rd_cnt");
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b1; addr = 8'd3; wdata = 32'd7; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({req_ready, rsp_valid, rdata, rsp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_mid_wait: ready/valid/rdata/err=%b/%b/%h/%b want 1/0/0/0",
               req_ready, rsp_valid, rdata, rsp_err);
    end
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = '0;
      for (int r = 0; r < 8; r++) m_scratch[d][r] = '0;
    end
    do_access(1'b0, 8'd3, 32'h0, "rst_rd3");
    do_access(1'b0, 8'd4, 32'h0, "rst_rd4");
    apply_reset();
    do_access(1'b0, 8'd1, 32'h0, "rst_rd_cnt");
  endtask

  task automatic test_back_to_back();
    logic        tw [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0]  ta [8] = '{8'd2, 8'd2, 8'd7, 8'd7, 8'd0, 8'd1, 8'd9, 8'd1};
    logic [31:0] td [8] = '{32'h1111_2222, 32'h0, 32'h7777_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5};
    int   idx = 0, got = 0, last_acc = -10, cyc = 0;
    exp_t e;
    rsp_ready_z = 1'b1;
    while (got < 8 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid_z === 1'b1) begin
        vectors++;
        if (cyc - last_acc != 1) begin
          miscompares++;
          $display("FAIL b2b latency #%0d: %0d cycles want 1", got, cyc - last_acc);
        end
        e = exp_z.pop_front();
        vectors++;
        if (rdata_z !== e.rdata || rsp_err_z !== e.err) begin
          miscompares++;
          $display("FAIL b2b rsp #%0d: rdata/err=%h/%b want %h/%b", got, rdata_z, rsp_err_z, e.rdata, e.err);
        end
        m_cnt[1] = m_cnt[1] + 1;
        got++;
      end
      if (req_ready_z === 1'b1 && idx < 8) begin
        if (idx > 0) begin
          vectors++;
          if (cyc - last_acc != 2) begin
            miscompares++;
            $display("FAIL b2b spacing #%0d: %0d cycles want 2", idx, cyc - last_acc);
          end
        end
        req_valid_z = 1'b1; req_wr_z = tw[idx]; addr_z = ta[idx]; wdata_z = td[idx];
        model_apply(1, tw[idx], ta[idx], td[idx], e);
        exp_z.push_back(e);
        last_acc = cyc;
        idx++;
      end else if (idx >= 8) begin
        req_valid_z = 1'b0;
      end
    end
    req_valid_z = 1'b0;
    vectors++;
    if (got != 8) begin
      miscompares++;
      $display("FAIL b2b count: %0d responses want 8 (timeout)", got);
    end
  endtask

  initial begin
    test_reset();
    test_id_read();
    test_scratch_rw();
    test_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
